// File: rtl/ir_ac_frame_rx.sv
// IR air-conditioner remote frame receiver: leader, 35-bit block, connect code, 32-bit block, stop mark.
// Filtered edges lag ir_in by 2+GLITCH cycles; frame_valid/frame_err are one-cycle strobes, no backpressure.
module ir_ac_frame_rx #(
  parameter int T_LEAD_MARK   = 1125000,
  parameter int T_LEAD_SPACE  = 562500,
  parameter int T_BIT_MARK    = 93750,
  parameter int T_ZERO_SPACE  = 56250,
  parameter int T_ONE_SPACE   = 187500,
  parameter int T_CONN_SPACE  = 2500000,
  parameter int GLITCH        = 16,
  parameter int IN_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [34:0] data35,
  output logic [31:0] data32,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int GW = (GLITCH > 1) ? $clog2(GLITCH + 1) : 1;
  localparam logic SPACE_RAW = (IN_ACTIVE_LOW != 0);

  localparam logic [21:0] LM_MIN = 22'(T_LEAD_MARK  - (T_LEAD_MARK  >> 2));
  localparam logic [21:0] LM_MAX = 22'(T_LEAD_MARK  + (T_LEAD_MARK  >> 2));
  localparam logic [21:0] LS_MIN = 22'(T_LEAD_SPACE - (T_LEAD_SPACE >> 2));
  localparam logic [21:0] LS_MAX = 22'(T_LEAD_SPACE + (T_LEAD_SPACE >> 2));
  localparam logic [21:0] BM_MIN = 22'(T_BIT_MARK   - (T_BIT_MARK   >> 2));
  localparam logic [21:0] BM_MAX = 22'(T_BIT_MARK   + (T_BIT_MARK   >> 2));
  localparam logic [21:0] ZS_MIN = 22'(T_ZERO_SPACE - (T_ZERO_SPACE >> 2));
  localparam logic [21:0] ZS_MAX = 22'(T_ZERO_SPACE + (T_ZERO_SPACE >> 2));
  localparam logic [21:0] OS_MIN = 22'(T_ONE_SPACE  - (T_ONE_SPACE  >> 2));
  localparam logic [21:0] OS_MAX = 22'(T_ONE_SPACE  + (T_ONE_SPACE  >> 2));
  localparam logic [21:0] CS_MIN = 22'(T_CONN_SPACE - (T_CONN_SPACE >> 2));
  localparam logic [21:0] CS_MAX = 22'(T_CONN_SPACE + (T_CONN_SPACE >> 2));
  localparam logic [21:0] TMO    = 22'(T_CONN_SPACE + (T_CONN_SPACE >> 2) + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_MARK,
    S_SPACE
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_sync1, r_sync2;
  logic [GW-1:0]   r_gcnt;
  logic            r_filt, r_filt_d;
  logic [21:0]     r_dur;
  logic [6:0]      r_seg;
  logic [34:0]     r_w35, r_data35;
  logic [31:0]     r_w32, r_data32;
  logic            r_valid, r_err;

  logic w_lvl, w_rise, w_fall, w_edge;
  logic w_err, w_shift, w_bit, w_seg_inc, w_seg_clr, w_done;

  function automatic logic in_win(input logic [21:0] v, input logic [21:0] lo, input logic [21:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // w_lvl is 1 while carrier is present, regardless of receiver polarity
  assign w_lvl  = (IN_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_rise = r_filt & ~r_filt_d;
  assign w_fall = ~r_filt & r_filt_d;
  assign w_edge = r_filt ^ r_filt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= SPACE_RAW;
      r_sync2  <= SPACE_RAW;
      r_gcnt   <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_sync1  <= ir_in;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (w_lvl != r_filt) begin
        if (r_gcnt == GW'(GLITCH - 1)) begin
          r_filt <= w_lvl;
          r_gcnt <= '0;
        end else begin
          r_gcnt <= r_gcnt + 1'b1;
        end
      end else begin
        r_gcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dur <= '0;
    end else if (w_edge) begin
      r_dur <= '0;
    end else if (r_dur != '1) begin
      r_dur <= r_dur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_err     = 1'b0;
    w_shift   = 1'b0;
    w_bit     = 1'b0;
    w_seg_inc = 1'b0;
    w_seg_clr = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_n = S_LEAD_MARK;
          w_seg_clr = 1'b1;
        end
      end
      S_LEAD_MARK: begin
        if (w_fall) begin
          if (in_win(r_dur, LM_MIN, LM_MAX)) w_state_n = S_LEAD_SPACE;
          else                               w_err     = 1'b1;
        end else if (r_dur > LM_MAX) begin
          w_err = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (w_rise) begin
          if (in_win(r_dur, LS_MIN, LS_MAX)) w_state_n = S_MARK;
          else                               w_err     = 1'b1;
        end
      end
      S_MARK: begin
        if (w_fall) begin
          if (!in_win(r_dur, BM_MIN, BM_MAX)) begin
            w_err = 1'b1;
          end else if (r_seg == 7'd68) begin
            w_done    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_SPACE;
          end
        end
      end
      S_SPACE: begin
        if (w_rise) begin
          w_state_n = S_MARK;
          w_seg_inc = 1'b1;
          if (r_seg == 7'd35) begin
            w_err = !in_win(r_dur, CS_MIN, CS_MAX);
          end else if (in_win(r_dur, ZS_MIN, ZS_MAX)) begin
            w_shift = 1'b1;
          end else if (in_win(r_dur, OS_MIN, OS_MAX)) begin
            w_shift = 1'b1;
            w_bit   = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // An edge always resets the count, so the timeout only applies between edges
    if (r_state != S_IDLE && !w_edge && r_dur >= TMO) w_err = 1'b1;
    if (w_err) begin
      w_state_n = S_IDLE;
      w_shift   = 1'b0;
      w_seg_inc = 1'b0;
      w_done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg    <= '0;
      r_w35    <= '0;
      r_w32    <= '0;
      r_data35 <= '0;
      r_data32 <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_err   <= w_err;
      if (w_err || w_seg_clr) begin
        r_seg <= '0;
        r_w35 <= '0;
        r_w32 <= '0;
      end else begin
        if (w_seg_inc) r_seg <= r_seg + 7'd1;
        if (w_shift) begin
          if (r_seg <= 7'd34) r_w35 <= {r_w35[33:0], w_bit};
          else                r_w32 <= {r_w32[30:0], w_bit};
        end
      end
      if (w_done) begin
        r_data35 <= r_w35;
        r_data32 <= r_w32;
      end
    end
  end

  assign data35      = r_data35;
  assign data32      = r_data32;
  assign frame_valid = r_valid;
  assign frame_err   = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/ir_ac_frame_rx.md
Name: ir_ac_frame_rx

Overview:
- Infrared receive decoder for the air-conditioner remote protocol.
- Takes the demodulated output of an IR receiver module and measures mark/space durations. Decodes one frame: leader, 35-bit block, connect code, 32-bit block, stop mark.
- Presents the two data words with a one-cycle valid strobe. It is the receive-side counterpart of the IR transmitter and runs on the same 125 MHz clock.

Parameters:
- T_LEAD_MARK, 1125000: leader mark length in clk cycles (9 ms).
- T_LEAD_SPACE, 562500: leader space length (4.5 ms).
- T_BIT_MARK, 93750: bit, connect and stop mark length (750 us).
- T_ZERO_SPACE, 56250: space after a mark for a 0 bit (450 us).
- T_ONE_SPACE, 187500: space after a mark for a 1 bit (1500 us).
- T_CONN_SPACE, 2500000: connect-code space (20 ms).
- GLITCH, 16: cycles a new input level must be stable before it is accepted.
- IN_ACTIVE_LOW, 1: 1 means ir_in low = carrier present (mark).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- ir_in  input  1  raw demodulated IR level, asynchronous to clk
- data35  output  35  last good first block; MSB = first bit received
- data32  output  32  last good second block; MSB = first bit received
- frame_valid  output  1  one-cycle pulse; data35/data32 updated in the same cycle
- frame_err  output  1  one-cycle pulse on any protocol violation or timeout
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; data35=0, data32=0, frame_valid=0, frame_err=0, busy=0. Synchronizer and filter are preset to the space level.
- Input path: 2-FF synchronizer, then polarity fix per IN_ACTIVE_LOW, then glitch filter. The filtered level changes only after GLITCH consecutive cycles at the new level. Pulses shorter than GLITCH cycles are ignored. Filtered-edge latency is 2+GLITCH cycles.
- Duration counter: 22 bits; cleared on every filtered edge; saturates at its maximum.
- Window for a nominal N: MIN = N - (N>>2), MAX = N + (N>>2) (±25%). Bit space decision: length in ZERO window gives 0; length in ONE window gives 1; any other length is an error.
- Segment counter seg (0..68) tracks position after the leader:
  - marks 0..34: bits of data35, MSB first;
  - mark 35: connect;
  - marks 36..67: bits of data32, MSB first;
  - mark 68: stop.
- Bits are shifted left into working registers. Outputs change only on frame_valid.
- IDLE: on filtered mark start, go to LEAD_MARK and clear seg.
- LEAD_MARK:
  - on mark end, length in LEAD_MARK window goes to LEAD_SPACE, otherwise error;
  - count exceeding the window MAX while still in mark is an immediate error.
- LEAD_SPACE: on mark start, length in LEAD_SPACE window goes to MARK, otherwise error.
- MARK:
  - on mark end, length must be in the BIT_MARK window, otherwise error;
  - if seg==68, go to IDLE and pulse frame_valid the cycle after the mark→space edge, loading data35/data32 from the working registers;
  - otherwise go to SPACE.
- SPACE: on mark start, classify the space that just ended:
  - seg<=34 or 36..67: bit space, shift the bit in;
  - seg==35: must be in the CONN_SPACE window.
  - Then seg++ and go to MARK.
- Timeout: in any non-IDLE state, a count reaching CONN_SPACE MAX+1 is an error.
- Error: pulse frame_err for one cycle, go to IDLE, leave outputs unchanged, clear the working registers.
  - If an error occurs at a mark start, the decoder waits for the next space before re-arming.
  - The error-causing mark is never reused as a leader.
- frame_valid and frame_err are never high in the same cycle.
- A new leader is accepted immediately after a frame_valid pulse (back-to-back frames).

Test Plan:
Scaled parameters for all scenarios: T_LEAD_MARK=900, T_LEAD_SPACE=450, T_BIT_MARK=75, T_ZERO_SPACE=45, T_ONE_SPACE=150, T_CONN_SPACE=2000, GLITCH=3, IN_ACTIVE_LOW=1.
- Nominal frame, data35=35'h4_1080_2052, data32=32'h0804_0006, with stop mark → exactly one frame_valid, outputs equal the sent values, frame_err never high, busy low afterwards.
- All durations +20% and then -20% → both frames valid with correct data. Bit-mark 30% long (98 cycles) at bit 5 → frame_err at that mark end, no frame_valid, outputs keep previous values.
- 2-cycle inverted glitches injected into every space and mark of a nominal frame → decoded data identical to the clean case.
- Input stuck at space after 10 bits of the first block → frame_err when the space count reaches 2501; busy=0 afterwards. A following good frame decodes correctly.
- rst asserted mid data32 block → outputs 0 immediately, busy=0. Next full frame → frame_valid with correct data.
- Two frames back-to-back (second leader 100 cycles after first stop mark), data differing in bit 0 of data32 → two frame_valid pulses, with the second set of values after the second pulse.
